// File: rtl/gpu_text_scanout.sv
// ---------------------------------------------------------------------------
// gpu_text_scanout: streams a text framebuffer (4 cells per 64-bit word) to a
// character pipeline with valid/ready handshake.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module gpu_text_scanout #(
  parameter int          COLS    = 80,
  parameter int          ROWS    = 30,
  parameter logic [63:0] FB_BASE = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] fb_address,
  input  logic [63:0] fb_data,
  output logic        fb_busy,
  output logic        char_valid,
  input  logic        char_ready,
  output logic [15:0] char_code,
  output logic [6:0]  char_col,
  output logic [4:0]  char_row,
  output logic        frame_done
);

  localparam logic [63:0] LAST_WORD = 64'(COLS * ROWS / 4 - 1);
  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] word_idx;
  logic [63:0] word_reg;
  logic [1:0]  lane;
  logic        handshake;

  assign fb_busy    = (state != IDLE);
  assign char_valid = (state == DRAIN);
  assign frame_done = (state == DONE);
  assign handshake  = char_valid & char_ready;
  assign char_code  = word_reg[{lane, 4'b0000} +: 16];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = DRAIN;
      DRAIN:   if (handshake && lane == 2'd3)
                 state_next = (word_idx == LAST_WORD) ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // fb_address is loaded on entry to ISSUE so it is already valid during ISSUE
  // and simply holds in every other state.
  always_ff @(posedge clock) begin
    if (reset) begin
      word_idx   <= '0;
      word_reg   <= '0;
      lane       <= '0;
      char_col   <= '0;
      char_row   <= '0;
      fb_address <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          word_idx   <= '0;
          lane       <= '0;
          char_col   <= '0;
          char_row   <= '0;
          fb_address <= FB_BASE;
        end
        CAPTURE: begin
          word_reg <= fb_data;
          lane     <= '0;
        end
        DRAIN: if (handshake) begin
          lane <= lane + 2'd1;
          if (char_col == LAST_COL) begin
            char_col <= '0;
            char_row <= (char_row == LAST_ROW) ? 5'd0 : char_row + 5'd1;
          end else begin
            char_col <= char_col + 7'd1;
          end
          if (lane == 2'd3 && word_idx != LAST_WORD) begin
            word_idx   <= word_idx + 64'd1;
            fb_address <= FB_BASE + word_idx + 64'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpu_text_scanout.sv
// ---------------------------------------------------------------------------
// tb_gpu_text_scanout: randomized-ready scan of default and small framebuffers
// against a cell-index reference model.                   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_gpu_text_scanout;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Default-size instance
  logic        reset_a, start_a, ready_a;
  logic [63:0] fb_address_a, fb_data_a;
  logic        fb_busy_a, char_valid_a, frame_done_a;
  logic [15:0] char_code_a;
  logic [6:0]  char_col_a;
  logic [4:0]  char_row_a;

  // Small instance: FB_BASE=100, COLS=8, ROWS=2
  logic        reset_b, start_b, ready_b;
  logic [63:0] fb_address_b, fb_data_b;
  logic        fb_busy_b, char_valid_b, frame_done_b;
  logic [15:0] char_code_b;
  logic [6:0]  char_col_b;
  logic [4:0]  char_row_b;

  gpu_text_scanout dut_a (
    .clock(clock), .reset(reset_a), .start(start_a),
    .fb_address(fb_address_a), .fb_data(fb_data_a), .fb_busy(fb_busy_a),
    .char_valid(char_valid_a), .char_ready(ready_a), .char_code(char_code_a),
    .char_col(char_col_a), .char_row(char_row_a), .frame_done(frame_done_a)
  );

  gpu_text_scanout #(.COLS(8), .ROWS(2), .FB_BASE(64'd100)) dut_b (
    .clock(clock), .reset(reset_b), .start(start_b),
    .fb_address(fb_address_b), .fb_data(fb_data_b), .fb_busy(fb_busy_b),
    .char_valid(char_valid_b), .char_ready(ready_b), .char_code(char_code_b),
    .char_col(char_col_b), .char_row(char_row_b), .frame_done(frame_done_b)
  );

  // Word k of the frame holds cell codes 4k..4k+3, lowest column in bits [15:0].
  function automatic logic [63:0] word_of(input logic [63:0] k);
    return {16'(4 * k + 3), 16'(4 * k + 2), 16'(4 * k + 1), 16'(4 * k)};
  endfunction

  // Synchronous-read framebuffer models
  always @(posedge clock) begin
    fb_data_a <= word_of(fb_address_a);
    fb_data_b <= word_of(fb_address_b - 64'd100);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_a(input string pfx);
    check({pfx, "_busy"},  fb_busy_a,    0);
    check({pfx, "_valid"}, char_valid_a, 0);
    check({pfx, "_done"},  frame_done_a, 0);
    check({pfx, "_addr"},  fb_address_a, 0);
    check({pfx, "_code"},  char_code_a,  0);
    check({pfx, "_col"},   char_col_a,   0);
    check({pfx, "_row"},   char_row_a,   0);
  endtask

  // Scan cells from the current cycle. Cell n must carry code n, column n%80,
  // row n/80 and be drained from word address n/4. Returns at the frame_done
  // cycle, or just after cell abort_at has been accepted when abort_at != 0.
  task automatic scan_a(input int rdy_pct, input int abort_at, output int cells);
    int n;
    bit stalled;
    bit finished;
    n = 0; stalled = 0; finished = 0;
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (stalled) check("stall_valid", char_valid_a, 1);
      if (char_valid_a) begin
        check("code", char_code_a, 64'(n));
        check("col",  char_col_a,  64'(n % 80));
        check("row",  char_row_a,  64'(n / 80));
        check("addr", fb_address_a, 64'(n / 4));
        check("busy", fb_busy_a, 1);
      end
      if (frame_done_a) begin
        check("done_cells", n, 2400);
        check("done_busy", fb_busy_a, 1);
        finished = 1;
      end else begin
        ready_a = ($urandom_range(99) < rdy_pct);
        stalled = char_valid_a && !ready_a;
        if (char_valid_a && ready_a) n++;
        step();
        if (abort_at != 0 && n == abort_at) finished = 1;
      end
    end
    if (!finished) check("timeout_a", 0, 1);
    cells = n;
  endtask

  // At the frame_done cycle: start here must be ignored, pulse must be single.
  task automatic end_of_frame();
    start_a = 1;
    step();
    start_a = 0;
    check("done_pulse", frame_done_a, 0);
    check("idle_busy", fb_busy_a, 0);
    step();
    check("start_at_done_ignored", fb_busy_a, 0);
    check("idle_done", frame_done_a, 0);
  endtask

  task automatic start_pulse_a();
    start_a = 1;
    step();
    start_a = 0;
  endtask

  initial begin
    int n;
    int lc;
    int lr;
    bit fin;
    reset_a = 1; reset_b = 1; start_a = 0; start_b = 0; ready_a = 0; ready_b = 0;
    repeat (3) step();
    check_reset_a("rst");
    check("rst_b_busy", fb_busy_b, 0);
    check("rst_b_addr", fb_address_b, 0);
    reset_a = 0; reset_b = 0;
    step();

    // Start latency and a full frame with ready held high
    start_a = 1;
    step();
    start_a = 0;
    check("lat_busy_t1", fb_busy_a, 1);
    check("lat_addr_issue", fb_address_a, 0);
    check("lat_valid_t1", char_valid_a, 0);
    step();
    check("lat_busy_t2", fb_busy_a, 1);
    check("lat_valid_t2", char_valid_a, 0);
    step();
    check("lat_valid_t3", char_valid_a, 1);
    scan_a(100, 0, n);
    end_of_frame();

    // Random backpressure
    start_pulse_a();
    scan_a(50, 0, n);
    end_of_frame();

    // Reset after cell 1000 is accepted, then a clean rescan
    start_pulse_a();
    scan_a(60, 1000, n);
    check("abort_cells", n, 1000);
    reset_a = 1;
    step();
    check_reset_a("abort");
    reset_a = 0;
    step();
    check("abort_no_done", frame_done_a, 0);
    check("abort_idle", fb_busy_a, 0);
    start_pulse_a();
    scan_a(70, 0, n);
    end_of_frame();

    // start held through a frame: exactly one frame, next begins after IDLE
    start_a = 1;
    step();
    scan_a(100, 0, n);
    step();
    check("hold_idle_busy", fb_busy_a, 0);
    check("hold_idle_done", frame_done_a, 0);
    step();
    check("hold_restart_busy", fb_busy_a, 1);
    check("hold_restart_addr", fb_address_a, 0);
    start_a = 0;
    scan_a(80, 0, n);
    end_of_frame();

    // Small geometry instance
    start_b = 1;
    step();
    start_b = 0;
    check("b_issue_addr", fb_address_b, 100);
    n = 0; fin = 0; lc = -1; lr = -1;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (char_valid_b) begin
        check("b_code", char_code_b, 64'(n));
        check("b_col",  char_col_b,  64'(n % 8));
        check("b_row",  char_row_b,  64'(n / 8));
        check("b_addr", fb_address_b, 64'(100 + n / 4));
      end
      if (frame_done_b) begin
        check("b_cells", n, 16);
        check("b_last_col", lc, 7);
        check("b_last_row", lr, 1);
        fin = 1;
      end else begin
        ready_b = ($urandom_range(99) < 70);
        if (char_valid_b && ready_b) begin
          n++;
          lc = int'(char_col_b);
          lr = int'(char_row_b);
        end
        step();
      end
    end
    if (!fin) check("timeout_b", 0, 1);
    step();
    check("b_done_pulse", frame_done_b, 0);
    check("b_idle_busy", fb_busy_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gpu_text_scanout.md
GPU_TEXT_SCANOUT -- requirements
Module: gpu_text_scanout

Interface
REQ-001 Parameter COLS, default 80, characters per text row.
REQ-002 Parameter ROWS, default 30, text rows per frame.
REQ-003 Parameter FB_BASE, default 0, framebuffer word address of character 0.
REQ-004 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to scan one frame; honoured only in IDLE.
REQ-007 fb_address  output  64  word address presented to the framebuffer read port.
REQ-008 fb_data  input  64  framebuffer read data; valid on the rising edge one cycle after fb_address was driven.
REQ-009 fb_busy  output  1  high while the block owns the framebuffer address port.
REQ-010 char_valid  output  1  char_code/char_col/char_row are valid.
REQ-011 char_ready  input  1  downstream accepts the character when high together with char_valid.
REQ-012 char_code  output  16  character code plus attribute for the current cell.
REQ-013 char_col  output  7  column of the current cell, 0..COLS-1.
REQ-014 char_row  output  5  row of the current cell, 0..ROWS-1.
REQ-015 frame_done  output  1  one-cycle pulse after the last cell of a frame is accepted.

Function
REQ-016 Each 64-bit word SHALL hold 4 cells: bits [15:0] in the lowest column, then [31:16], [47:32], and [63:48].
REQ-017 COLS*ROWS SHALL be a multiple of 4; the frame SHALL occupy words FB_BASE through FB_BASE+COLS*ROWS/4-1, with 600 words at the defaults.
REQ-018 The FSM SHALL have the states IDLE, ISSUE, CAPTURE, DRAIN, and DONE.
REQ-019 IDLE to ISSUE on start; the cell index, word index, column, and row SHALL clear to 0.
REQ-020 ISSUE SHALL drive fb_address = FB_BASE + word index for one cycle, then go to CAPTURE.
REQ-021 CAPTURE SHALL latch fb_data into a 64-bit word register, set the lane counter to 0, and go to DRAIN.
REQ-022 DRAIN SHALL assert char_valid with char_code = lane [lane*16+15:lane*16] of the word register.
REQ-023 In DRAIN, char_code, char_col, and char_row SHALL hold stable while char_valid=1 and char_ready=0.
REQ-024 On each handshake (char_valid and char_ready), the lane SHALL increment, and the column SHALL increment, wrapping COLS-1 to 0 with a row increment.
REQ-025 A handshake on lane 3 SHALL increment the word index and go to ISSUE, except for the last word of the frame, which SHALL go to DONE.
REQ-026 DONE SHALL pulse frame_done for exactly one cycle, then go to IDLE.
REQ-027 fb_busy SHALL be high in ISSUE, CAPTURE, DRAIN, and DONE, and low in IDLE.
REQ-028 fb_address SHALL hold its last driven value outside ISSUE.
REQ-029 char_valid SHALL be 0 in every state other than DRAIN.
REQ-030 start while not in IDLE SHALL be ignored, with no restart and no queuing.
REQ-031 start asserted in the same cycle as the frame_done pulse SHALL be ignored; a new frame SHALL begin only on start seen in IDLE.
REQ-032 Minimum latency from start to the first char_valid SHALL be 3 cycles: ISSUE, CAPTURE, then DRAIN.
REQ-033 Peak throughput SHALL be 4 cells per 6 cycles when char_ready is held high.
REQ-034 Word-index and address arithmetic SHALL be 64-bit unsigned; the column and row SHALL never exceed COLS-1 and ROWS-1.

Reset
REQ-035 On reset, the FSM SHALL go to IDLE and char_valid, frame_done, and fb_busy SHALL be 0.
REQ-036 On reset, fb_address, char_code, char_col, char_row, and the word, lane, and index registers SHALL be 0.
REQ-037 Reset asserted mid-frame, in any state, SHALL abort the frame with no frame_done; the next start SHALL rescan from cell 0.

Verification
REQ-038 Defaults, framebuffer model word k = {16'(4k+3),16'(4k+2),16'(4k+1),16'(4k)}, char_ready=1, start pulse: the bench SHALL check 2400 cells with char_code = 0..2399 in order, col/row wrap 79->0 and 0->1, last cell (79,29), one frame_done, and fb_address sweeping 0..599.
REQ-039 Same stimulus with char_ready random 50%: the bench SHALL check an identical sequence and outputs stable while stalled.
REQ-040 start at t, check cycle by cycle: fb_busy=1 at t+1, fb_address=0 in ISSUE, and first char_valid at t+3.
REQ-041 Reset asserted after cell 1000 is accepted: the bench SHALL check all outputs return to reset values the next cycle, no frame_done, and a new start scanning from char_code 0.
REQ-042 start held high for the entire frame: the bench SHALL check exactly one frame per IDLE visit and that the re-entry to IDLE begins the next frame.
REQ-043 FB_BASE=100, COLS=8, ROWS=2: the bench SHALL check fb_address sequence 100..103, 16 cells, and frame_done after cell (7,1).
